// File: rtl/frac_decim_coeff_loader.sv
// rtl/frac_decim_coeff_loader.sv - coefficient reload controller for the single-MAC fractional decimator
// Optional COEFF_CHECKSUM_EN adds CoeffSum_o, the sign-extended sum of the beats of the current reload.
module frac_decim_coeff_loader #(
  parameter int CoeffNum     = 16,
  parameter int AddrWidth    = 4,
  parameter int CoeffWidth   = 18,
  parameter int DataWidth    = 18,
  parameter int SettleCycles = 8
) (
  input  logic                  Clk_i,
  input  logic                  Rst_i,
  input  logic                  Start_i,
  input  logic [CoeffWidth-1:0] CoeffData_i,
  input  logic                  CoeffValid_i,
  output logic                  CoeffReady_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  input  logic [DataWidth-1:0]  Data_i,
  input  logic                  DataNd_i,
  output logic                  DecRst_o,
  output logic [AddrWidth-1:0]  DecCoeffAddr_o,
  output logic [CoeffWidth-1:0] DecCoeffData_o,
  output logic                  DecCoeffWr_o,
  output logic [DataWidth-1:0]  DecData_o,
  output logic                  DecDataNd_o,
  output logic [15:0]           DropCnt_o
`ifdef COEFF_CHECKSUM_EN
  ,
  output logic [CoeffWidth+AddrWidth-1:0] CoeffSum_o
`endif
);

  localparam int SetW = $clog2(SettleCycles + 1);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(CoeffNum - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  hold_cnt_q, hold_cnt_d;
  logic [AddrWidth-1:0]  addr_cnt_q, addr_cnt_d;
  logic [SetW-1:0]       settle_cnt_q, settle_cnt_d;

  logic                  coeff_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dec_rst_q;
  logic                  wr_q;
  logic [AddrWidth-1:0]  wr_addr_q;
  logic [CoeffWidth-1:0] wr_data_q;
  logic [DataWidth-1:0]  dec_data_q;
  logic                  dec_nd_q;
  logic [15:0]           drop_cnt_q;

  logic accept;
  logic pass_d;
  logic drop_d;

  // The ready register is high exactly while in LOAD, so it also qualifies acceptance.
  assign accept = CoeffValid_i & coeff_ready_q;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    addr_cnt_d   = addr_cnt_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          state_d    = S_HOLD;
          hold_cnt_d = 1'b1;
          addr_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 1'b0) state_d = S_LOAD;
        else                    hold_cnt_d = 1'b0;
      end
      S_LOAD: begin
        if (accept) begin
          addr_cnt_d = addr_cnt_q + AddrWidth'(1);
          if (addr_cnt_q == LastAddr) begin
            state_d      = S_SETTLE;
            settle_cnt_d = SetW'(SettleCycles);
          end
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) state_d = S_DONE;
        else                    settle_cnt_d = settle_cnt_q - SetW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A restart mid-reload wins over every other transition; DONE is left to finish.
    if (Start_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d    = S_HOLD;
      hold_cnt_d = 1'b1;
      addr_cnt_d = '0;
    end
  end

  assign pass_d = DataNd_i && (state_d == S_IDLE);
  assign drop_d = DataNd_i && (state_d != S_IDLE);

`ifdef COEFF_CHECKSUM_EN
  logic [CoeffWidth+AddrWidth-1:0] sum_q;
  logic [CoeffWidth+AddrWidth-1:0] beat_ext;
  assign beat_ext   = {{AddrWidth{CoeffData_i[CoeffWidth-1]}}, CoeffData_i};
  assign CoeffSum_o = sum_q;
`endif

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= 1'b0;
      addr_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      coeff_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dec_rst_q     <= 1'b1;
      wr_q          <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      dec_data_q    <= '0;
      dec_nd_q      <= 1'b0;
      drop_cnt_q    <= '0;
`ifdef COEFF_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      coeff_ready_q <= (state_d == S_LOAD);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      dec_rst_q     <= (state_d == S_HOLD) || (state_d == S_LOAD);
      wr_q          <= accept;
      if (accept) begin
        wr_addr_q <= addr_cnt_q;
        wr_data_q <= CoeffData_i;
      end
      dec_data_q <= Data_i;
      dec_nd_q   <= pass_d;
      if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
`ifdef COEFF_CHECKSUM_EN
      // HOLD never accepts beats, so clearing throughout HOLD equals clearing on entry.
      if (state_d == S_HOLD) sum_q <= '0;
      else if (accept)       sum_q <= sum_q + beat_ext;
`endif
    end
  end

  assign CoeffReady_o   = coeff_ready_q;
  assign Busy_o         = busy_q;
  assign Done_o         = done_q;
  assign DecRst_o       = dec_rst_q;
  assign DecCoeffAddr_o = wr_addr_q;
  assign DecCoeffData_o = wr_data_q;
  assign DecCoeffWr_o   = wr_q;
  assign DecData_o      = dec_data_q;
  assign DecDataNd_o    = dec_nd_q;
  assign DropCnt_o      = drop_cnt_q;

endmodule
